// File: rtl/fc_sched_pkg.sv
// Shared types and elaboration helpers for the fully-connected layer scheduler.
// Derived constants are computed from the instance parameters via these functions.
package fc_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    DRAIN,
    WRITE,
    DONE
  } state_e;

  localparam int DEF_INNEURON  = 64;
  localparam int DEF_OUTNEURON = 10;
  localparam int DEF_PO        = 2;
  localparam int DEF_RD_LAT    = 1;
  localparam int DEF_MAC_LAT   = 3;

  function automatic int pairs_of(input int inneuron);
    return inneuron / 2;
  endfunction

  function automatic int groups_of(input int outneuron, input int po);
    return outneuron / po;
  endfunction

  function automatic int drain_of(input int rd_lat, input int mac_lat);
    return rd_lat + mac_lat;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit fits(input int val, input int width);
    return (width >= 31) || (val < (1 << width));
  endfunction

endpackage

// File: rtl/fc_issue_pipe.sv
// RD_LAT-deep delay line turning read issues into MAC enable / sload strobes,
// so the MAC lanes see each operand pair the cycle its RAM data arrives.
module fc_issue_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic issue_valid,
  input  logic issue_first,
  output logic mult_ena,
  output logic accum_sload
);

  logic [RD_LAT-1:0] valid_q, valid_d;
  logic [RD_LAT-1:0] sload_q, sload_d;

  // NOTE: every variable driven here gets a default before any condition,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    valid_d    = valid_q << 1;
    sload_d    = sload_q << 1;
    valid_d[0] = issue_valid;
    sload_d[0] = issue_valid & issue_first;
  end

  // NOTE: sequential state uses non-blocking assignment so every flop in the
  // design samples the same pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      sload_q <= '0;
    end else begin
      valid_q <= valid_d;
      sload_q <= sload_d;
    end
  end

  assign mult_ena    = valid_q[RD_LAT-1];
  assign accum_sload = sload_q[RD_LAT-1];

endmodule

// File: rtl/fc_layer_scheduler.sv
// Sequencer for one fully-connected layer pass: walks output groups, issues
// paired input/weight reads, drains the MAC pipeline and strobes the result write.
module fc_layer_scheduler
  import fc_sched_pkg::*;
#(
  parameter int INNEURON                = DEF_INNEURON,
  parameter int OUTNEURON               = DEF_OUTNEURON,
  parameter int PO                      = DEF_PO,
  parameter int RD_LAT                  = DEF_RD_LAT,
  parameter int MAC_LAT                 = DEF_MAC_LAT,
  parameter int FC_INNEURON_ADDR_WIDTH  = 6,
  parameter int FC_WEIGHT_ADDR_WIDTH    = 10,
  parameter int FC_OUTNEURON_ADDR_WIDTH = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               stall,
  output logic                               busy,
  output logic                               done,
  output logic [FC_INNEURON_ADDR_WIDTH-1:0]  in_addra,
  output logic [FC_INNEURON_ADDR_WIDTH-1:0]  in_addrb,
  output logic                               in_rden,
  output logic [FC_WEIGHT_ADDR_WIDTH-1:0]    w_addra,
  output logic [FC_WEIGHT_ADDR_WIDTH-1:0]    w_addrb,
  output logic                               w_rden,
  output logic                               mult_ena,
  output logic                               accum_sload,
  output logic                               mult_clr,
  output logic                               wr_en,
  output logic [FC_OUTNEURON_ADDR_WIDTH-1:0] wr_addr
);

  localparam int PAIRS     = pairs_of(INNEURON);
  localparam int GROUPS    = groups_of(OUTNEURON, PO);
  localparam int DRAIN_CYC = drain_of(RD_LAT, MAC_LAT);
  localparam int PW        = cnt_width(PAIRS);
  localparam int GW        = cnt_width(GROUPS);
  localparam int DW        = cnt_width(DRAIN_CYC);
  localparam int IAW       = FC_INNEURON_ADDR_WIDTH;
  localparam int WAW       = FC_WEIGHT_ADDR_WIDTH;
  localparam int OAW       = FC_OUTNEURON_ADDR_WIDTH;

  if (INNEURON < 2 || (INNEURON % 2) != 0 || PO < 1 || (OUTNEURON % PO) != 0 ||
      OUTNEURON < PO || RD_LAT < 1 || MAC_LAT < 0 ||
      !fits(INNEURON - 1, IAW) || !fits(GROUPS * INNEURON - 1, WAW) ||
      !fits(GROUPS - 1, OAW)) begin : g_param_check
    $error("fc_layer_scheduler: parameter set does not fit the address ports");
  end

  state_e          state_q, state_d;
  logic [PW-1:0]   pair_q, pair_d;
  logic [GW-1:0]   group_q, group_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            clr_q, clr_d;
  logic            wr_en_q, wr_en_d;
  logic [OAW-1:0]  wr_addr_q, wr_addr_d;

  logic            in_issue;
  logic            issue;
  logic            last_pair;
  logic            last_group;
  logic [WAW-1:0]  w_even;

  assign in_issue   = (state_q == ISSUE);
  assign issue      = in_issue && !stall;
  assign last_pair  = (pair_q == PW'(PAIRS - 1));
  assign last_group = (group_q == GW'(GROUPS - 1));

  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    group_d = group_q;
    drain_d = drain_q;
    case (state_q)
      IDLE:  if (start) state_d = CLEAR;
      CLEAR: begin
        pair_d  = '0;
        group_d = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (issue) begin
          if (last_pair) begin
            pair_d  = '0;
            drain_d = DW'(DRAIN_CYC - 1);
            state_d = DRAIN;
          end else begin
            pair_d = pair_q + PW'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = WRITE;
        else               drain_d = drain_q - DW'(1);
      end
      WRITE: begin
        // The first sload of the next group restarts accumulation, so no re-clear.
        if (last_group) begin
          state_d = DONE;
        end else begin
          group_d = group_q + GW'(1);
          state_d = ISSUE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    clr_d     = (state_d == CLEAR);
    wr_en_d   = (state_d == WRITE);
    wr_addr_d = (state_d == WRITE) ? OAW'(group_d) : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pair_q    <= '0;
      group_q   <= '0;
      drain_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clr_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      pair_q    <= pair_d;
      group_q   <= group_d;
      drain_q   <= drain_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      clr_q     <= clr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  // Addresses follow the counters, so a stalled ISSUE cycle holds them.
  assign w_even   = WAW'(32'(group_q) * 32'(INNEURON) + 32'({pair_q, 1'b0}));
  assign in_addra = in_issue ? IAW'({pair_q, 1'b0}) : '0;
  assign in_addrb = in_issue ? IAW'({pair_q, 1'b1}) : '0;
  assign w_addra  = in_issue ? w_even : '0;
  assign w_addrb  = in_issue ? (w_even + WAW'(1)) : '0;
  assign in_rden  = issue;
  assign w_rden   = issue;

  assign busy     = busy_q;
  assign done     = done_q;
  assign mult_clr = clr_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;

  fc_issue_pipe #(
    .RD_LAT(RD_LAT)
  ) u_issue_pipe (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue),
    .issue_first (pair_q == '0),
    .mult_ena    (mult_ena),
    .accum_sload (accum_sload)
  );

endmodule
